// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer on the free-running refclk.
// Pulses PLL reset, waits for a qualified lock, then releases system reset.
module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 100,
  parameter int LOCK_TIMEOUT  = 100000,
  parameter int STABLE_CYCLES = 1000,
  parameter int MAX_RETRIES   = 4,
  parameter int CNT_W         = 20
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       pll_ready,
  output logic       fault,
  output logic [2:0] state_o,
  output logic [3:0] retry_count,
  output logic [7:0] loss_count
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAULT  = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] RST_END = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_END  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_END = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD   = CNT_W'(4);
  localparam logic [3:0]       MAX_R   = 4'(MAX_RETRIES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             sync1_q, sync2_q;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;
  logic             fail;
  logic [3:0]       retry_inc;
  logic             locked_s;

  assign locked_s  = sync2_q;
  assign retry_inc = retry_q + 4'd1;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + CNT_W'(1);
    retry_d = retry_q;
    loss_d  = loss_q;
    fail    = 1'b0;
    unique case (state_q)
      S_RESET: begin
        if (timer_q == RST_END) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (timer_q >= GUARD && locked_s) state_d = S_STABLE;
        else if (timer_q == TO_END) fail = 1'b1;
      end
      S_STABLE: begin
        if (!locked_s) begin
          fail = 1'b1;
        end else if (timer_q == STB_END) begin
          state_d = S_RUN;
          retry_d = 4'd0;
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          state_d = S_RESET;
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end
      end
      S_FAULT: timer_d = timer_q;
      default: state_d = S_RESET;
    endcase
    // A failed attempt either retries or gives up once the limit is hit
    if (fail) begin
      retry_d = retry_inc;
      state_d = (retry_inc == MAX_R) ? S_FAULT : S_RESET;
    end
    if (restart) begin
      state_d = S_RESET;
      retry_d = 4'd0;
    end
    if (restart || state_d != state_q) timer_d = '0;
    pll_rst_d   = (state_d == S_RESET) || (state_d == S_FAULT);
    sys_rst_n_d = (state_d == S_RUN);
    ready_d     = (state_d == S_RUN);
    fault_d     = (state_d == S_FAULT);
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q     <= S_RESET;
      timer_q     <= '0;
      retry_q     <= 4'd0;
      loss_q      <= 8'd0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      sync1_q     <= pll_locked;
      sync2_q     <= sync1_q;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_rst_n   = sys_rst_n_q;
  assign pll_ready   = ready_q;
  assign fault       = fault_q;
  assign state_o     = state_q;
  assign retry_count = retry_q;
  assign loss_count  = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer.
// Stimulus queues cycle-tagged expectations; a monitor compares them.
module tb_pll_reset_sequencer;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       pll_ready;
  logic       fault;
  logic [2:0] state_o;
  logic [3:0] retry_count;
  logic [7:0] loss_count;

  pll_reset_sequencer #(
    .RST_CYCLES   (8),
    .LOCK_TIMEOUT (64),
    .STABLE_CYCLES(16),
    .MAX_RETRIES  (3),
    .CNT_W        (20)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .restart    (restart),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .pll_ready  (pll_ready),
    .fault      (fault),
    .state_o    (state_o),
    .retry_count(retry_count),
    .loss_count (loss_count)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    int       cyc;
    string    nm;
    logic [2:0] st;
    int       rc;
    int       lc;
  } exp_t;

  exp_t sbq[$];
  exp_t me;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   el = 0;
  int   nl;
  int   b;

  always @(posedge refclk) cyc <= cyc + 1;

  always begin
    logic [18:0] act, exv;
    @(negedge refclk);
    #1;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      me = sbq.pop_front();
      checks++;
      act = {state_o, pll_rst, sys_rst_n, pll_ready, fault,
             retry_count, loss_count};
      exv = {me.st, (me.st == 3'd0 || me.st == 3'd4),
             (me.st == 3'd3), (me.st == 3'd3), (me.st == 3'd4),
             4'(me.rc), 8'(me.lc)};
      if (me.cyc < cyc) begin
        errors++;
        $display("FAIL %s: missed at cycle %0d (now %0d)",
                 me.nm, me.cyc, cyc);
      end else if (act !== exv) begin
        errors++;
        $display("FAIL %s @%0d: got st=%0d rst=%b sys=%b rdy=%b flt=%b rc=%0d lc=%0d, want st=%0d rst=%b sys=%b rdy=%b flt=%b rc=%0d lc=%0d",
                 me.nm, cyc, act[18:16], act[15], act[14], act[13],
                 act[12], act[11:8], act[7:0], exv[18:16], exv[15],
                 exv[14], exv[13], exv[12], exv[11:8], exv[7:0]);
      end
    end
  end

  task automatic ex(input int t, input string nm, input logic [2:0] st,
                    input int rc, input int lc);
    exp_t e;
    e.cyc = t;
    e.nm  = nm;
    e.st  = st;
    e.rc  = rc;
    e.lc  = lc;
    sbq.push_back(e);
  endtask

  task automatic at(input int t);
    while (cyc < t) @(negedge refclk);
  endtask

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    restart    = 1'b0;
    at(3);
    // nominal start
    b = cyc;
    ex(b, "reset_state", 3'd0, 0, 0);
    rst_n = 1'b1;
    ex(b + 7, "pll_rst_8th", 3'd0, 0, 0);
    ex(b + 8, "wait_entry", 3'd1, 0, 0);
    at(b + 28);
    b = cyc;
    pll_locked = 1'b1;
    ex(b + 2, "sync_latency", 3'd1, 0, 0);
    ex(b + 3, "stable_entry", 3'd2, 0, 0);
    ex(b + 18, "stable_last", 3'd2, 0, 0);
    ex(b + 19, "run_entry", 3'd3, 0, 0);
    at(b + 19);
    // repeated loss of lock in RUN
    for (int i = 0; i < 300; i++) begin
      b = cyc;
      pll_locked = 1'b0;
      nl = (el < 255) ? el + 1 : 255;
      ex(b + 2, "loss_pre", 3'd3, 0, el);
      ex(b + 3, "loss_drop", 3'd0, 0, nl);
      el = nl;
      ex(b + 11, "loss_wait", 3'd1, 0, el);
      ex(b + 15, "loss_guard", 3'd1, 0, el);
      ex(b + 16, "loss_stable", 3'd2, 0, el);
      ex(b + 32, "loss_run", 3'd3, 0, el);
      at(b + 1);
      pll_locked = 1'b1;
      at(b + 32);
    end
    // unstable lock in STABLE
    b = cyc;
    restart = 1'b1;
    ex(b + 1, "restart_run", 3'd0, 0, el);
    ex(b + 9, "unst_wait", 3'd1, 0, el);
    ex(b + 14, "unst_stable", 3'd2, 0, el);
    ex(b + 26, "unst_hold", 3'd2, 0, el);
    ex(b + 27, "unst_drop", 3'd0, 1, el);
    at(b + 1);
    restart = 1'b0;
    at(b + 24);
    pll_locked = 1'b0;
    at(b + 27);
    // lock never arrives
    b = cyc;
    restart = 1'b1;
    ex(b + 1, "nl_restart", 3'd0, 0, el);
    ex(b + 8, "nl_rst1", 3'd0, 0, el);
    ex(b + 9, "nl_wait1", 3'd1, 0, el);
    ex(b + 72, "nl_wait1_end", 3'd1, 0, el);
    ex(b + 73, "nl_retry1", 3'd0, 1, el);
    ex(b + 80, "nl_rst2", 3'd0, 1, el);
    ex(b + 81, "nl_wait2", 3'd1, 1, el);
    ex(b + 144, "nl_wait2_end", 3'd1, 1, el);
    ex(b + 145, "nl_retry2", 3'd0, 2, el);
    ex(b + 152, "nl_rst3", 3'd0, 2, el);
    ex(b + 153, "nl_wait3", 3'd1, 2, el);
    ex(b + 216, "nl_wait3_end", 3'd1, 2, el);
    ex(b + 217, "nl_fault", 3'd4, 3, el);
    ex(b + 417, "nl_fault_hold", 3'd4, 3, el);
    at(b + 1);
    restart = 1'b0;
    at(b + 417);
    // recover from FAULT
    b = cyc;
    restart = 1'b1;
    pll_locked = 1'b1;
    ex(b + 1, "rec_reset", 3'd0, 0, el);
    ex(b + 9, "rec_wait", 3'd1, 0, el);
    ex(b + 14, "rec_stable", 3'd2, 0, el);
    ex(b + 29, "rec_stable_end", 3'd2, 0, el);
    ex(b + 30, "rec_run", 3'd3, 0, el);
    at(b + 1);
    restart = 1'b0;
    at(b + 30);
    // drop coincident with STABLE expiry
    b = cyc;
    restart = 1'b1;
    ex(b + 14, "co_stable", 3'd2, 0, el);
    ex(b + 29, "co_stable_14", 3'd2, 0, el);
    ex(b + 30, "co_drop_wins", 3'd0, 1, el);
    at(b + 1);
    restart = 1'b0;
    at(b + 27);
    pll_locked = 1'b0;
    // restart coincident with WAIT_LOCK timeout
    ex(b + 38, "co_wait", 3'd1, 1, el);
    ex(b + 101, "co_wait_end", 3'd1, 1, el);
    ex(b + 102, "co_restart", 3'd0, 0, el);
    ex(b + 110, "co_rewait", 3'd1, 0, el);
    at(b + 101);
    restart = 1'b1;
    at(b + 102);
    restart = 1'b0;
    at(b + 115);
    while (sbq.size() > 0) begin
      me = sbq.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: never compared (due %0d)", me.nm, me.cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
